// File: rtl/hazard_tracker.sv
// Load-use hazard tracker: carries EX/MEM destination records and inserts a single
// bubble when the ID instruction consumes a load result that is still in EX.
module hazard_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ID,
  input  logic [4:0]  Rd_ID,
  input  logic        RegWrite_ID,
  input  logic        MemRead_ID,
  input  logic [4:0]  addrA,
  input  logic [4:0]  addrB,
  input  logic        usesA,
  input  logic        usesB,
  input  logic        flush,
  output logic [4:0]  Rd_EX,
  output logic [4:0]  Rd_MEM,
  output logic        RegWrite_IDEX,
  output logic        RegWrite_EXMEM,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam int DATA_W = 16;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam stage_t BUBBLE = '{rd: 5'd31, reg_write: 1'b0, mem_read: 1'b0};

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  stage_t             id_p0;
  stage_t             ex_p1;
  stage_t             mem_p2;
  state_t             state_p1;
  logic [DATA_W-1:0]  cnt_p1;
  logic               hazard;

  // ID stage: decode record and hazard detection against the EX record
  always_comb begin
    id_p0  = '{rd: Rd_ID, reg_write: RegWrite_ID, mem_read: MemRead_ID};
    hazard = valid_ID && ex_p1.mem_read && (ex_p1.rd != 5'd31) &&
             ((usesA && (addrA == ex_p1.rd)) || (usesB && (addrB == ex_p1.rd)));
    stall  = hazard && !flush;
  end

  // EX/MEM stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_p1  <= BUBBLE;
      mem_p2 <= BUBBLE;
    end else begin
      mem_p2 <= ex_p1;
      ex_p1  <= (flush || stall || !valid_ID) ? BUBBLE : id_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= RUN;
      cnt_p1   <= '0;
    end else begin
      if (stall) cnt_p1 <= sat_inc(cnt_p1);
      case (state_p1)
        RUN:      if (stall) state_p1 <= LU_STALL;
        LU_STALL: state_p1 <= RUN;
        default:  state_p1 <= RUN;
      endcase
    end
  end

  assign Rd_EX          = ex_p1.rd;
  assign RegWrite_IDEX  = ex_p1.reg_write;
  assign Rd_MEM         = mem_p2.rd;
  assign RegWrite_EXMEM = mem_p2.reg_write;
  assign stall_count    = cnt_p1;

endmodule
